// File: rtl/add_result_stage.sv
// add_result_stage: capture stage behind the carry-select adder.
// Each accepted beat stores the adder result {cout, sum} in a small circular FIFO toward the
// consumer.
// Optional result checking is compiled in with `define ADD_RESULT_CHECK_EN.
// When it is enabled, the stage compares the adder result against a behavioural sum, tags each
// entry with a mismatch bit and keeps a saturating mismatch count.
// When it is disabled, o_mismatch and o_err_cnt are tied to zero.
module add_result_stage #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_add_term1,
  input  logic [WIDTH-1:0]         i_add_term2,
  input  logic [WIDTH-1:0]         i_sum,
  input  logic                     i_cout,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_sum,
  output logic                     o_cout,
  output logic                     o_mismatch,
  output logic [7:0]               o_err_cnt,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] sum_mem  [DEPTH];
  logic             cout_mem [DEPTH];
  logic             push, pop;

  // Ready depends only on registered occupancy, so a pop never frees a slot in the same cycle.
  assign o_ready = (count_q != CW'(DEPTH));
  assign o_valid = (count_q != '0);
  assign o_count = count_q;
  assign push    = i_valid && o_ready;
  assign pop     = o_valid && i_ready;

  // Next-state for the pointers and occupancy; pointers wrap naturally since DEPTH is 2^AW.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset discards any buffered entries.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset: the outputs are masked whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) begin
      sum_mem[wr_ptr_q]  <= i_sum;
      cout_mem[wr_ptr_q] <= i_cout;
    end
  end

  // Head entry, forced to zero when nothing is buffered.
  always_comb begin
    o_sum  = '0;
    o_cout = 1'b0;
    if (o_valid) begin
      o_sum  = sum_mem[rd_ptr_q];
      o_cout = cout_mem[rd_ptr_q];
    end
  end

`ifdef ADD_RESULT_CHECK_EN
  logic [WIDTH:0] ref_sum;
  logic           beat_mismatch;
  logic           mis_mem [DEPTH];
  logic [7:0]     err_cnt_q, err_cnt_d;

  assign ref_sum       = {1'b0, i_add_term1} + {1'b0, i_add_term2};
  assign beat_mismatch = ({i_cout, i_sum} != ref_sum);

  // Per-entry mismatch tag travels alongside the stored result.
  always_ff @(posedge i_clk) begin
    if (push) mis_mem[wr_ptr_q] <= beat_mismatch;
  end

  // Saturating mismatch count; only pushed beats are counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (push && beat_mismatch && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Mismatch counter register, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) err_cnt_q <= '0;
    else          err_cnt_q <= err_cnt_d;
  end

  assign o_mismatch = o_valid & mis_mem[rd_ptr_q];
  assign o_err_cnt  = err_cnt_q;
`else
  // Operands are only consumed by the checker.
  logic unused_check;
  assign unused_check = ^{i_add_term1, i_add_term2};
  assign o_mismatch   = 1'b0;
  assign o_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_add_result_stage.sv
// Self-checking bench for add_result_stage.
// A queue-based reference model tracks FIFO contents and the saturating mismatch count.
module tb_add_result_stage;

  localparam int WIDTH = 7;
  localparam int DEPTH = 4;
`ifdef ADD_RESULT_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             valid = 1'b0;
  logic             rdy = 1'b0;
  logic [WIDTH-1:0] a = '0, b = '0, s = '0;
  logic             c = 1'b0;

  logic             o_ready, o_valid, o_cout, o_mismatch;
  logic [WIDTH-1:0] o_sum;
  logic [7:0]       o_err_cnt;
  logic [2:0]       o_count;

  add_result_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (valid),
    .o_ready     (o_ready),
    .i_add_term1 (a),
    .i_add_term2 (b),
    .i_sum       (s),
    .i_cout      (c),
    .o_valid     (o_valid),
    .i_ready     (rdy),
    .o_sum       (o_sum),
    .o_cout      (o_cout),
    .o_mismatch  (o_mismatch),
    .o_err_cnt   (o_err_cnt),
    .o_count     (o_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int cout;
    int mis;
  } ent_t;

  ent_t q[$];
  int   err_model = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Compare every DUT output against the model's view of the FIFO.
  task automatic check_outputs();
    int ev, es, ec, em;
    ev = (q.size() != 0) ? 1 : 0;
    es = ev ? q[0].sum : 0;
    ec = ev ? q[0].cout : 0;
    em = ev ? q[0].mis : 0;
    chk("o_valid", int'(o_valid), ev);
    chk("o_ready", int'(o_ready), (q.size() < DEPTH) ? 1 : 0);
    chk("o_count", int'(o_count), q.size());
    chk("o_sum", int'(o_sum), es);
    chk("o_cout", int'(o_cout), ec);
    chk("o_mismatch", int'(o_mismatch), em);
    chk("o_err_cnt", int'(o_err_cnt), err_model);
  endtask

  // One clock: check, decide handshakes from the model, advance past the edge, update model.
  task automatic cycle();
    bit   push, pop;
    ent_t e;
    check_outputs();
    push   = valid && (q.size() < DEPTH);
    pop    = rdy && (q.size() != 0);
    e.sum  = int'(s);
    e.cout = int'(c);
    e.mis  = (CHK && ((int'(c) * 128 + int'(s)) != (int'(a) + int'(b)))) ? 1 : 0;
    @(posedge clk);
    #1;
    if (pop) void'(q.pop_front());
    if (push) begin
      q.push_back(e);
      if (e.mis != 0 && err_model < 255) err_model++;
    end
  endtask

  task automatic drive(input bit v, input int aa, input int bb, input int ss, input int cc,
                       input bit r);
    valid = v;
    a     = WIDTH'(aa);
    b     = WIDTH'(bb);
    s     = WIDTH'(ss);
    c     = cc[0];
    rdy   = r;
    cycle();
  endtask

  // Beat with the correct adder result.
  task automatic good(input int aa, input int bb, input bit r);
    int t;
    t = aa + bb;
    drive(1'b1, aa, bb, t % 128, t / 128, r);
  endtask

  task automatic do_reset();
    #2;
    valid = 1'b0;
    rdy   = 1'b0;
    rst_n = 1'b0;
    #1;
    q.delete();
    err_model = 0;
    check_outputs();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_outputs();
  endtask

  initial begin
    int sv;
    do_reset();

    // Simple correct beat, visible next cycle.
    drive(1'b1, 5, 3, 8, 0, 1'b1);
    chk("tp1_sum", int'(o_sum), 8);
    chk("tp1_valid", int'(o_valid), 1);
    drive(1'b0, 0, 0, 0, 0, 1'b1);

    // Carry out, then an injected wrong sum.
    drive(1'b1, 127, 1, 0, 1, 1'b1);
    chk("carry_cout", int'(o_cout), 1);
    drive(1'b1, 127, 1, 1, 1, 1'b1);
    chk("inj_mismatch", int'(o_mismatch), CHK ? 1 : 0);
    chk("inj_errcnt", int'(o_err_cnt), CHK ? 1 : 0);
    drive(1'b0, 0, 0, 0, 0, 1'b1);

    // Fill with the consumer stalled, hold a 5th beat, then drain.
    for (int i = 0; i < 4; i++) good(i + 10, i, 1'b0);
    chk("full_count", int'(o_count), 4);
    chk("full_ready", int'(o_ready), 0);
    for (int i = 0; i < 3; i++) good(50, 7, 1'b0);
    // Full with push and pop together: pop only, push lands next cycle.
    good(50, 7, 1'b1);
    chk("full_pop_only", int'(o_count), 3);
    good(50, 7, 1'b1);
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 0, 0, 0, 1'b1);

    // Wrap-around stream with random operands.
    for (int i = 0; i < 10; i++) good($urandom_range(0, 127), $urandom_range(0, 127), 1'b1);
    drive(1'b0, 0, 0, 0, 0, 1'b1);

    // Random handshakes with occasional corrupted sums.
    for (int i = 0; i < 200; i++) begin
      int aa, bb, t;
      aa = $urandom_range(0, 127);
      bb = $urandom_range(0, 127);
      t  = aa + bb;
      if ($urandom_range(0, 3) == 0) t = $urandom_range(0, 255);
      drive(1'($urandom_range(0, 1)), aa, bb, t % 128, t / 128, 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 6; i++) drive(1'b0, 0, 0, 0, 0, 1'b1);

    // Saturation of the mismatch counter.
    for (int i = 0; i < 300; i++) begin
      sv = $urandom_range(0, 127);
      drive(1'b1, sv, 1, sv, 1, 1'b1);
    end
    chk("err_saturated", int'(o_err_cnt), CHK ? 255 : 0);

    // Reset in the middle of a stream with entries buffered.
    for (int i = 0; i < 3; i++) good(i, i, 1'b0);
    do_reset();
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_errcnt", int'(o_err_cnt), 0);
    good(20, 22, 1'b1);
    drive(1'b0, 0, 0, 0, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/add_result_stage.md
# add_result_stage

Downstream capture stage for the 7-bit carry-select adder. The source presents operands to the adder and to this block in the same cycle. On each accepted beat this block samples the adder's `sum`/`cout` together with the operands and buffers the result in a small FIFO toward the consumer. When the check feature is compiled in, it also compares the adder result against a behavioural sum and counts mismatches.

## Interface
Parameters:
- `WIDTH`, 7: operand and sum width.
- `DEPTH`, 4: result FIFO entries; power of two, ≥2.

Ports:
- `i_clk` in 1: sole clock; all state on rising edge.
- `i_rst_n` in 1: reset, asynchronous and active-low.
- `i_valid` in 1: source has operands and adder result valid this cycle.
- `o_ready` in/out: out 1; block can accept a beat.
- `i_add_term1` in WIDTH: operand A (same value driven to the adder).
- `i_add_term2` in WIDTH: operand B.
- `i_sum` in WIDTH: adder `sum` output.
- `i_cout` in 1: adder `cout` output.
- `o_valid` out 1: FIFO head available.
- `i_ready` in 1: consumer accepts head.
- `o_sum` out WIDTH: head sum.
- `o_cout` out 1: head carry.
- `o_mismatch` out 1: head beat failed check.
- `o_err_cnt` out 8: saturating mismatch count.
- `o_count` out clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- Push:
  - Occurs when `i_valid && o_ready`.
  - Stores {`i_cout`, `i_sum`, mismatch bit}.
  - Mismatch = ({`i_cout`, `i_sum`} != `i_add_term1` + `i_add_term2`, computed WIDTH+1 bits, zero-extended).
- Pop:
  - Occurs when `o_valid && i_ready`.
  - Head advances.
- FIFO storage:
  - Circular buffer with rd/wr pointers of clog2(DEPTH) bits that wrap modulo DEPTH.
  - Occupancy counter of clog2(DEPTH)+1 bits.
- `o_ready` = (`o_count` != DEPTH).
  - Depends on registered state only; no combinational path from `i_ready`.
  - When full, a simultaneous pop does not enable a push in the same cycle.
- `o_valid` = (`o_count` != 0).
- When `o_valid`=0, `o_sum`, `o_cout` and `o_mismatch` are driven 0. When `o_valid`=1 they show the head entry.
- Push and pop in the same cycle (not full, not empty): occupancy unchanged, both pointers advance.
- Push to empty FIFO: the entry is visible at the outputs the next cycle.
- `o_err_cnt`:
  - +1 on each pushed beat with mismatch=1.
  - Saturates at 255 and never wraps.
  - Cleared only by reset.
- `i_valid` while `o_ready`=0: the beat is ignored. The source must hold it; no state changes.

## Timing
- Latency: a beat accepted at edge N appears on `o_valid`/`o_sum` after edge N, i.e. usable in cycle N+1.
- Throughput: 1 beat/cycle while not full.
- Adder path: `i_sum`/`i_cout` are sampled at the same edge as the operands. The source guarantees that the combinational adder settles within the cycle.
- Reset (asserted at any time, including mid-stream):
  - Immediately clears pointers and occupancy, so `o_valid`=0 and `o_ready`=1 after deassert.
  - `o_sum`=0, `o_cout`=0, `o_mismatch`=0, `o_err_cnt`=0, `o_count`=0.
  - In-flight entries are discarded.
- Occupancy changes by at most ±1 per cycle.

## Configuration
- `ADD_RESULT_CHECK_EN` defined:
  - Reference adder, comparator, the per-entry mismatch bit and `o_err_cnt` logic are compiled in.
- `ADD_RESULT_CHECK_EN` undefined:
  - No comparator and no mismatch storage.
  - `o_mismatch` and `o_err_cnt` are tied to 0.
  - FIFO, handshakes and latency are identical.

## Test plan
- Reset, then push A=7'h05 and B=7'h03 with adder outputs sum=7'h08, cout=0, `i_ready`=1 → next cycle `o_valid`=1, `o_sum`=7'h08, `o_cout`=0, `o_mismatch`=0, `o_err_cnt`=0.
- Push A=7'h7F, B=7'h01, sum=7'h00, cout=1 → `o_cout`=1, `o_sum`=0, no mismatch. Then push the same operands with sum=7'h01 injected → `o_mismatch`=1 on that entry, `o_err_cnt`=1.
- `i_ready`=0, push 4 beats (DEPTH=4) → `o_count`=4, `o_ready`=0. A 5th beat is held for 3 cycles with no state change. Raise `i_ready` → the first 4 pop in order, then the held beat is accepted.
- Full FIFO with `i_valid`=1 and `i_ready`=1 in the same cycle → pop only, `o_count` 4→3. The push is accepted the following cycle.
- Wrap-around: stream 10 beats at `i_valid`=`i_ready`=1 → outputs match in order, 1-cycle latency, no bubbles after the first.
- Inject 300 mismatching beats → `o_err_cnt` stops at 255. Assert `i_rst_n`=0 mid-stream → all outputs 0 and `o_ready`=1 after release.
- Rebuild without `ADD_RESULT_CHECK_EN` and rerun the mismatch case → `o_mismatch`=0 and `o_err_cnt`=0.
